// File: rtl/bp_choice_meta_queue.sv
// Purpose: per-fetch metadata queue feeding the tournament chooser's update port (lbp/gbp/unaligned per fetch block).
// Latency: push tag is combinational; lookup result is registered, valid one cycle after the request.
// Backpressure: push_ready_o drops when full or during flush; pop on empty is ignored.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  discard all entries, squash in-flight lookup
//   push_*                   fetch-side capture (valid/ready, records, unaligned), push_tag_o = write slot
//   pop_i                    release the oldest entry
//   lookup_valid_i/tag_i     resolution-time read request
//   lookup_valid_o/hit_o     registered read response
//   update_*_o               stored metadata for the chooser (zero on miss)
//   occupancy_o              number of allocated entries
module bp_choice_meta_queue #(
  parameter int INSTR_PER_FETCH = 2,
  parameter int PRED_W          = 2,
  parameter int DEPTH           = 8,
  parameter int TAG_W           = $clog2(DEPTH)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              push_valid_i,
  output logic                              push_ready_o,
  input  logic [INSTR_PER_FETCH*PRED_W-1:0] push_lbp_pred_i,
  input  logic [INSTR_PER_FETCH*PRED_W-1:0] push_gbp_pred_i,
  input  logic                              push_unaligned_i,
  output logic [TAG_W-1:0]                  push_tag_o,
  input  logic                              pop_i,
  input  logic                              lookup_valid_i,
  input  logic [TAG_W-1:0]                  lookup_tag_i,
  output logic                              lookup_valid_o,
  output logic                              lookup_hit_o,
  output logic [INSTR_PER_FETCH*PRED_W-1:0] update_lbp_pred_o,
  output logic [INSTR_PER_FETCH*PRED_W-1:0] update_gbp_pred_o,
  output logic                              update_is_unaligned_o,
  output logic [TAG_W:0]                    occupancy_o
);

  localparam int REC_W = INSTR_PER_FETCH * PRED_W;

  logic [TAG_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0]   lbp_q [DEPTH];
  logic [REC_W-1:0]   gbp_q [DEPTH];
  logic [DEPTH-1:0]   unal_q;
  logic [DEPTH-1:0]   alloc_q, alloc_d;

  logic               lk_vld_q, lk_vld_d, lk_hit_q, lk_hit_d, lk_unal_q, lk_unal_d;
  logic [REC_W-1:0]   lk_lbp_q, lk_lbp_d, lk_gbp_q, lk_gbp_d;

  logic [TAG_W-1:0]   wr_idx, rd_idx;
  logic               empty, full, push_acc, pop_acc;

  assign wr_idx = wr_ptr_q[TAG_W-1:0];
  assign rd_idx = rd_ptr_q[TAG_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[TAG_W] != rd_ptr_q[TAG_W]);

  // Ready reflects the pre-pop state, so a full queue refuses a push even when popping.
  assign push_ready_o = !full && !flush_i;
  assign push_acc     = push_valid_i && push_ready_o;
  assign pop_acc      = pop_i && !empty && !flush_i;

  assign push_tag_o  = wr_idx;
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

  assign wr_ptr_d = flush_i ? '0 : wr_ptr_q + {{TAG_W{1'b0}}, push_acc};
  assign rd_ptr_d = flush_i ? '0 : rd_ptr_q + {{TAG_W{1'b0}}, pop_acc};

  // push and pop never target the same slot: that would need full (push refused) or empty (pop ignored).
  always_comb begin
    alloc_d = alloc_q;
    if (flush_i) begin
      alloc_d = '0;
    end else begin
      if (pop_acc)  alloc_d[rd_idx] = 1'b0;
      if (push_acc) alloc_d[wr_idx] = 1'b1;
    end
  end

  // Lookup reads pre-update state: a same-cycle push misses, a same-cycle pop still hits.
  always_comb begin
    lk_vld_d  = 1'b0;
    lk_hit_d  = lk_hit_q;
    lk_lbp_d  = lk_lbp_q;
    lk_gbp_d  = lk_gbp_q;
    lk_unal_d = lk_unal_q;
    if (lookup_valid_i && !flush_i) begin
      lk_vld_d  = 1'b1;
      lk_hit_d  = alloc_q[lookup_tag_i];
      lk_lbp_d  = alloc_q[lookup_tag_i] ? lbp_q[lookup_tag_i]  : '0;
      lk_gbp_d  = alloc_q[lookup_tag_i] ? gbp_q[lookup_tag_i]  : '0;
      lk_unal_d = alloc_q[lookup_tag_i] ? unal_q[lookup_tag_i] : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      alloc_q   <= '0;
      lk_vld_q  <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_lbp_q  <= '0;
      lk_gbp_q  <= '0;
      lk_unal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      alloc_q   <= alloc_d;
      lk_vld_q  <= lk_vld_d;
      lk_hit_q  <= lk_hit_d;
      lk_lbp_q  <= lk_lbp_d;
      lk_gbp_q  <= lk_gbp_d;
      lk_unal_q <= lk_unal_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        lbp_q[i] <= '0;
        gbp_q[i] <= '0;
      end
      unal_q <= '0;
    end else if (push_acc) begin
      lbp_q[wr_idx]  <= push_lbp_pred_i;
      gbp_q[wr_idx]  <= push_gbp_pred_i;
      unal_q[wr_idx] <= push_unaligned_i;
    end
  end

  assign lookup_valid_o        = lk_vld_q;
  assign lookup_hit_o          = lk_hit_q;
  assign update_lbp_pred_o     = lk_lbp_q;
  assign update_gbp_pred_o     = lk_gbp_q;
  assign update_is_unaligned_o = lk_unal_q;

endmodule

// File: tb/tb_bp_choice_meta_queue.sv
module tb_bp_choice_meta_queue;
  localparam int DEPTH = 8;

  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       flush_i = 0, push_valid_i = 0, push_unaligned_i = 0, pop_i = 0, lookup_valid_i = 0;
  logic [3:0] push_lbp_pred_i = 0, push_gbp_pred_i = 0;
  logic [2:0] lookup_tag_i = 0;
  logic       push_ready_o, lookup_valid_o, lookup_hit_o, update_is_unaligned_o;
  logic [2:0] push_tag_o;
  logic [3:0] update_lbp_pred_o, update_gbp_pred_o, occupancy_o;

  bp_choice_meta_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_lbp_pred_i(push_lbp_pred_i), .push_gbp_pred_i(push_gbp_pred_i),
    .push_unaligned_i(push_unaligned_i), .push_tag_o(push_tag_o), .pop_i(pop_i),
    .lookup_valid_i(lookup_valid_i), .lookup_tag_i(lookup_tag_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .update_lbp_pred_o(update_lbp_pred_o), .update_gbp_pred_o(update_gbp_pred_o),
    .update_is_unaligned_o(update_is_unaligned_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: FIFO of in-flight fetch blocks, each remembering its tag.
  typedef struct {
    int       tag;
    bit [3:0] lbp;
    bit [3:0] gbp;
    bit       un;
  } ent_t;

  ent_t q[$];
  int   next_tag;
  int   n_cmp, n_mis;
  bit   e_vld, e_hit, e_un, data_known;
  bit [3:0] e_lbp, e_gbp;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    next_tag = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit pv, input bit pp, input bit lv, input int lt, input bit fl,
                      input bit [3:0] l, input bit [3:0] g, input bit u);
    bit ready_e;
    push_valid_i = pv; pop_i = pp; lookup_valid_i = lv; lookup_tag_i = lt[2:0];
    flush_i = fl; push_lbp_pred_i = l; push_gbp_pred_i = g; push_unaligned_i = u;
    #1;
    ready_e = (q.size() < DEPTH) && !fl;
    check("push_ready", push_ready_o, ready_e);
    check("push_tag", push_tag_o, next_tag);

    if (fl) begin
      e_vld = 0;
      if (lv) data_known = 0;
    end else if (lv) begin
      e_vld = 1; e_hit = 0; e_lbp = 0; e_gbp = 0; e_un = 0; data_known = 1;
      foreach (q[i]) if (q[i].tag == lt) begin
        e_hit = 1; e_lbp = q[i].lbp; e_gbp = q[i].gbp; e_un = q[i].un;
      end
    end else begin
      e_vld = 0;
    end

    if (fl) model_clear();
    else begin
      if (pp && q.size() > 0) void'(q.pop_front());
      if (pv && ready_e) begin
        q.push_back('{tag: next_tag, lbp: l, gbp: g, un: u});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end

    @(posedge clk_i);
    #1;
    check("lookup_valid", lookup_valid_o, e_vld);
    check("occupancy", occupancy_o, q.size());
    if (e_vld) check("lookup_hit", lookup_hit_o, e_hit);
    if (data_known) begin
      check("upd_lbp", update_lbp_pred_o, e_lbp);
      check("upd_gbp", update_gbp_pred_o, e_gbp);
      check("upd_unal", update_is_unaligned_o, e_un);
    end
  endtask

  task automatic push(input bit [3:0] l, input bit [3:0] g, input bit u);
    step(1, 0, 0, 0, 0, l, g, u);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    model_clear();
    e_vld = 0; e_hit = 0; e_lbp = 0; e_gbp = 0; e_un = 0; data_known = 1;

    // Reset state
    #12;
    check("rst_ready", push_ready_o, 1);
    check("rst_tag", push_tag_o, 0);
    check("rst_occ", occupancy_o, 0);
    check("rst_lk_valid", lookup_valid_o, 0);
    check("rst_lk_hit", lookup_hit_o, 0);
    check("rst_upd", {update_lbp_pred_o, update_gbp_pred_o, update_is_unaligned_o}, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    // Single push then lookup
    push(4'b1011, 4'b1100, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check("single_hit", lookup_hit_o, 1);
    check("single_lbp", update_lbp_pred_o, 4'b1011);

    // Fill to full, refused 9th push, push+pop while full
    for (int i = 1; i < DEPTH; i++) push(4'(i), 4'(15 - i), 1'(i));
    check("full_ready", push_ready_o, 0);
    check("full_occ", occupancy_o, 8);
    push(4'hF, 4'hF, 1);
    step(1, 1, 0, 0, 0, 4'h5, 4'h5, 0);
    check("full_pushpop_occ", occupancy_o, 7);

    // Wrap-around: tags reused after pops
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) push(4'(i), 4'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    push(4'hA, 4'h1, 1);
    push(4'hB, 4'h2, 0);
    push(4'hC, 4'h3, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    check("wrap_lbp", update_lbp_pred_o, 4'hB);
    check("wrap_occ", occupancy_o, 8);
    step(0, 0, 0, 0, 0, 0, 0, 0);   // data must hold with no request

    // Same-cycle hazards
    step(0, 0, 0, 0, 1, 0, 0, 0);
    push(4'h3, 4'h6, 1);
    push(4'h7, 4'h9, 0);
    step(1, 0, 1, 2, 0, 4'hE, 4'hD, 1);
    check("rbw_hit", lookup_hit_o, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    check("pop_lk_hit", lookup_hit_o, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check("after_pop_hit", lookup_hit_o, 0);

    // Flush priority over push/pop/lookup
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i + 2), 1);
    step(1, 1, 1, 2, 1, 4'h1, 4'h1, 1);
    check("flush_tag", push_tag_o, 0);
    step(0, 0, 1, 3, 0, 0, 0, 0);
    check("flush_lk_hit", lookup_hit_o, 0);

    // Empty pop
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("empty_pop_tag", push_tag_o, 0);

    // Async reset while a lookup result is pending
    push(4'h9, 4'h6, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    #2 rst_ni = 0;
    #1;
    check("arst_lk_valid", lookup_valid_o, 0);
    check("arst_occ", occupancy_o, 0);
    model_clear();
    e_lbp = 0; e_gbp = 0; e_un = 0; data_known = 1;
    #3 rst_ni = 1;
    @(posedge clk_i); #1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 40) == 0,
           4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
